// File: rtl/nand_arb_pkg.sv
// Shared types and constants for the two-port nand_master arbiter.
// State encodings stay plain logic constants so external checkers can bind to them.
package nand_arb_pkg;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE      = 3'd0;
  localparam arb_state_t ST_ISSUE     = 3'd1;
  localparam arb_state_t ST_SETTLE    = 3'd2;
  localparam arb_state_t ST_WAIT_BUSY = 3'd3;
  localparam arb_state_t ST_DONE      = 3'd4;

  localparam logic [7:0] CMD_READ_ID   = 8'h03;
  localparam logic [7:0] CMD_DISABLE   = 8'h08;
  localparam logic [7:0] CMD_ENABLE    = 8'h09;
  localparam logic [7:0] CMD_READ_BYTE = 8'h0E;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] data;
    logic       lock;
  } arb_req_t;

endpackage

// File: rtl/nand_arb_rr2.sv
// Two-way round-robin pick. While a lock is held, only the owner's request is visible.
module nand_arb_rr2
  import nand_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last,
  input  logic       i_lock_valid,
  input  logic       i_owner,
  output logic       o_grant,
  output logic       o_grant_valid
);

  logic [1:0] w_cand;

  always_comb begin
    w_cand = i_valid;
    if (i_lock_valid) begin
      w_cand = i_owner ? (i_valid & 2'b10) : (i_valid & 2'b01);
    end
    o_grant_valid = |w_cand;
    // On a tie the port that did not win last time goes first.
    if (w_cand == 2'b11) begin
      o_grant = ~i_last;
    end else begin
      o_grant = w_cand[1];
    end
  end

endmodule

// File: rtl/nand_master_arbiter.sv
// Arbiter and single-command sequencer in front of nand_master: grant, pulse activate,
// wait out busy, return data_out to the owner. An optional lock keeps ownership across commands.
module nand_master_arbiter
  import nand_arb_pkg::*;
#(
  parameter int ISSUE_WAIT   = 2,
  parameter int BUSY_TIMEOUT = 4096,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       req0_valid,
  input  logic [7:0] req0_cmd,
  input  logic [7:0] req0_data,
  input  logic       req0_lock,
  output logic       req0_ready,
  output logic       req0_done,
  output logic       req0_err,
  output logic [7:0] req0_rdata,
  input  logic       req1_valid,
  input  logic [7:0] req1_cmd,
  input  logic [7:0] req1_data,
  input  logic       req1_lock,
  output logic       req1_ready,
  output logic       req1_done,
  output logic       req1_err,
  output logic [7:0] req1_rdata,
  output logic       nm_activate,
  output logic [7:0] nm_cmd_in,
  output logic [7:0] nm_data_in,
  input  logic       nm_busy,
  input  logic [7:0] nm_data_out,
  output logic [2:0] dbg_state
);

  localparam int SW = $clog2(ISSUE_WAIT + 2);
  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_t    r_state;
  logic [SW-1:0] r_settle_cnt;
  logic [BW-1:0] r_busy_cnt;
  logic [LW-1:0] r_lock_cnt;
  logic          r_grant, r_last, r_lock_valid, r_owner, r_req_lock, r_fail;
  logic [7:0]    r_cmd, r_data, r_rdata0, r_rdata1;
  logic          r_activate;
  logic [1:0]    r_ready, r_done, r_err;

  logic          w_grant, w_grant_valid;
  arb_req_t      w_req;

  nand_arb_rr2 u_rr2 (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last       (r_last),
    .i_lock_valid (r_lock_valid),
    .i_owner      (r_owner),
    .o_grant      (w_grant),
    .o_grant_valid(w_grant_valid)
  );

  always_comb begin
    w_req = '{cmd: req0_cmd, data: req0_data, lock: req0_lock};
    if (w_grant) w_req = '{cmd: req1_cmd, data: req1_data, lock: req1_lock};
  end

  // Handshake: a requester holds valid/cmd/data/lock until it sees its one-cycle ready;
  // the request is captured on that grant, so inputs may change from the ready cycle on.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_busy_cnt   <= '0;
      r_lock_cnt   <= '0;
      r_grant      <= 1'b0;
      r_last       <= 1'b1;
      r_lock_valid <= 1'b0;
      r_owner      <= 1'b0;
      r_req_lock   <= 1'b0;
      r_fail       <= 1'b0;
      r_cmd        <= '0;
      r_data       <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_activate   <= 1'b0;
      r_ready      <= '0;
      r_done       <= '0;
      r_err        <= '0;
    end else begin
      r_activate <= 1'b0;
      r_ready    <= '0;
      r_done     <= '0;
      r_err      <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_state          <= ST_ISSUE;
            r_activate       <= 1'b1;
            r_ready[w_grant] <= 1'b1;
            r_grant          <= w_grant;
            r_last           <= w_grant;
            r_cmd            <= w_req.cmd;
            r_data           <= w_req.data;
            r_req_lock       <= w_req.lock;
            r_lock_cnt       <= '0;
          end else if (r_lock_valid) begin
            if (r_lock_cnt == LW'(LOCK_TIMEOUT - 1)) begin
              r_lock_valid <= 1'b0;
              r_lock_cnt   <= '0;
            end else begin
              r_lock_cnt <= r_lock_cnt + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          r_settle_cnt <= '0;
          r_busy_cnt   <= '0;
          r_state      <= (ISSUE_WAIT == 0) ? ST_WAIT_BUSY : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_settle_cnt == SW'(ISSUE_WAIT - 1)) r_state <= ST_WAIT_BUSY;
          else r_settle_cnt <= r_settle_cnt + 1'b1;
        end
        ST_WAIT_BUSY: begin
          if (!nm_busy) begin
            r_state         <= ST_DONE;
            r_done[r_grant] <= 1'b1;
            r_fail          <= 1'b0;
            if (r_grant) r_rdata1 <= nm_data_out;
            else         r_rdata0 <= nm_data_out;
          end else if (r_busy_cnt == BW'(BUSY_TIMEOUT - 1)) begin
            r_state         <= ST_DONE;
            r_done[r_grant] <= 1'b1;
            r_err[r_grant]  <= 1'b1;
            r_fail          <= 1'b1;
            if (r_grant) r_rdata1 <= '0;
            else         r_rdata0 <= '0;
          end else begin
            r_busy_cnt <= r_busy_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_lock_cnt   <= '0;
          r_lock_valid <= r_req_lock && !r_fail;
          r_owner      <= r_grant;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready  = r_ready[0];
  assign req1_ready  = r_ready[1];
  assign req0_done   = r_done[0];
  assign req1_done   = r_done[1];
  assign req0_err    = r_err[0];
  assign req1_err    = r_err[1];
  assign req0_rdata  = r_rdata0;
  assign req1_rdata  = r_rdata1;
  assign nm_activate = r_activate;
  assign nm_cmd_in   = r_cmd;
  assign nm_data_in  = r_data;
  assign dbg_state   = r_state;

endmodule
